ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter; the send direction of the keyboard link whose receive side is PS2_Interface.

---
 rtl/ps2_host_tx.sv | 251 +++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
//
// Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to a PS/2 device.
// The shared lines are driven open-drain: the top level ties
// ps2_x = oe ? 1'b0 : 1'bz and feeds the raw line levels back in.
//
// Optional feature macro: PS2_TX_AUTO_RETRY_EN
//   defined   - a timeout or missing ACK silently restarts the transfer from
//               INHIBIT with the same byte, up to 2 retries; tx_error pulses
//               only after the third failure.
//   undefined - the first failure pulses tx_error; no retry logic exists.
//
// Ports:
//   clock        in   system clock (50 MHz)
//   resetn       in   asynchronous active-low reset
//   tx_valid     in   byte request, accepted when tx_valid && tx_ready
//   tx_data      in   [7:0] command byte
//   tx_ready     out  idle, can accept a byte
//   tx_done      out  1-cycle pulse: byte sent and ACK received
//   tx_error     out  1-cycle pulse: timeout or missing ACK
//   ps2_clk_in   in   raw ps2_clock line level (asynchronous)
//   ps2_data_in  in   raw ps2_data line level (asynchronous)
//   ps2_clk_oe   out  1 = pull ps2_clock low
//   ps2_data_oe  out  1 = pull ps2_data low

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned RTS_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam int unsigned PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int PW = $clog2(PH_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] RTS_LAST = PW'(RTS_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    // Line synchronizers; idle lines are high, so reset to 1 to avoid a
    // spurious falling edge when reset is released.
    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;

    logic sync_clk;
    logic sync_data;
    logic fall;

    assign sync_clk  = clk_sync_q[1];
    assign sync_data = data_sync_q[1];
    assign fall      = clk_prev_q & ~sync_clk;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    state_t        state_q;
    logic [7:0]    byte_q;
    logic          parity_q;
    logic [3:0]    bit_cnt_q;
    logic [PW-1:0] phase_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          tx_ready_q;
    logic          tx_done_q;
    logic          tx_error_q;
    logic          clk_oe_q;
    logic          data_oe_q;
`ifdef PS2_TX_AUTO_RETRY_EN
    logic [1:0]    retry_q;
`endif

    assign tx_ready    = tx_ready_q;
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

    // States in which the device owns the clock and the watchdog runs.
    logic wire_phase;
    logic idle_seen;
    logic timeout_hit;
    logic noack;
    logic fail;

    assign wire_phase  = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // Completion in WAIT_IDLE wins over a timeout landing in the same cycle.
    assign idle_seen   = (state_q == S_WAIT_IDLE) && sync_clk && sync_data;
    assign timeout_hit = wire_phase && !fall && (to_cnt_q == TO_LAST) && !idle_seen;
    assign noack       = (state_q == S_ACK) && fall && sync_data;
    assign fail        = timeout_hit || noack;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            byte_q      <= 8'h00;
            parity_q    <= 1'b0;
            bit_cnt_q   <= 4'd0;
            phase_cnt_q <= '0;
            to_cnt_q    <= '0;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_error_q  <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
`ifdef PS2_TX_AUTO_RETRY_EN
            retry_q     <= 2'd0;
`endif
        end else begin
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;

            // Watchdog: cycles since the last device clock fall, saturating.
            if (wire_phase) begin
                if (fall) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q != TO_LAST) begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
            end

            if (fail) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
`ifdef PS2_TX_AUTO_RETRY_EN
                if (retry_q != 2'd2) begin
                    retry_q     <= retry_q + 2'd1;
                    clk_oe_q    <= 1'b1;
                    phase_cnt_q <= '0;
                    bit_cnt_q   <= 4'd0;
                    state_q     <= S_INHIBIT;
                end else begin
                    tx_error_q <= 1'b1;
                    tx_ready_q <= 1'b1;
                    state_q    <= S_IDLE;
                end
`else
                tx_error_q <= 1'b1;
                tx_ready_q <= 1'b1;
                state_q    <= S_IDLE;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tx_valid && tx_ready_q) begin
                            byte_q      <= tx_data;
                            parity_q    <= ~^tx_data;
                            tx_ready_q  <= 1'b0;
                            clk_oe_q    <= 1'b1;
                            phase_cnt_q <= '0;
                            state_q     <= S_INHIBIT;
`ifdef PS2_TX_AUTO_RETRY_EN
                            retry_q     <= 2'd0;
`endif
                        end
                    end

                    S_INHIBIT: begin
                        if (phase_cnt_q == INH_LAST) begin
                            phase_cnt_q <= '0;
                            data_oe_q   <= 1'b1;   // start bit
                            state_q     <= S_RTS;
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    S_RTS: begin
                        if (phase_cnt_q == RTS_LAST) begin
                            clk_oe_q  <= 1'b0;     // hand the clock to the device
                            bit_cnt_q <= 4'd0;
                            to_cnt_q  <= '0;
                            state_q   <= S_SEND;
                        end else begin
                            phase_cnt_q <= phase_cnt_q + 1'b1;
                        end
                    end

                    S_SEND: begin
                        // Data changes only after a detected fall, i.e. while
                        // the clock is low; the device samples on the rise.
                        if (fall) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q < 4'd8) begin
                                data_oe_q <= ~byte_q[bit_cnt_q[2:0]];
                            end else if (bit_cnt_q == 4'd8) begin
                                data_oe_q <= ~parity_q;
                            end else begin
                                data_oe_q <= 1'b0; // stop bit (released)
                                state_q   <= S_ACK;
                            end
                        end
                    end

                    S_ACK: begin
                        // Data high on this fall is handled as noack above.
                        if (fall) begin
                            bit_cnt_q <= 4'd11;
                            state_q   <= S_WAIT_IDLE;
                        end
                    end

                    S_WAIT_IDLE: begin
                        if (idle_seen) begin
                            tx_done_q  <= 1'b1;
                            tx_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end

                    default: begin
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH      = 200;
    localparam int RTS      = 16;
    localparam int TMO      = 3000;
    localparam int HALF     = 20;
    // Two synchronizer stages plus the edge register between a line fall
    // and the watchdog clearing.
    localparam int SYNC_LAT = 3;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       ps2_clk_in;
    logic       ps2_data_in;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: frame bits as the device sees them on the line.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            ones += int'(b[i]);
        end
        f[8] = (ones % 2 == 0);   // odd parity over data + parity
        f[9] = 1'b1;              // stop
        return f;
    endfunction

    typedef struct {
        bit         ok;
        logic [9:0] frame;
    } exp_t;

    exp_t       sb_q[$];
    int         pulses = 0;
    int         err_cyc = 0;
    int         last_fall_cyc = 0;
    logic [9:0] dev_frame = '0;
    int         n_acc = 0;

    always @(posedge clock) if (resetn && tx_valid && tx_ready) n_acc <= n_acc + 1;

    // Monitor: pops one expectation per completion/error pulse.
    always @(negedge clock) begin
        if (resetn && (tx_done || tx_error)) begin
            exp_t e;
            check("done_error_exclusive", int'(tx_done & tx_error), 0);
            check("ready_with_pulse", int'(tx_ready), 1);
            check("lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
            check("pulse_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("outcome_done", int'(tx_done), int'(e.ok));
                if (e.ok && tx_done) check("frame", dev_frame, e.frame);
            end
            if (tx_error) err_cyc = cyc;
            pulses++;
        end
    end

    // Inhibit / request-to-send phase lengths.
    int inh_n = 0;
    int rts_n = 0;
    always @(negedge clock) begin
        if (!resetn) begin
            inh_n = 0;
            rts_n = 0;
        end else if (ps2_clk_oe && !ps2_data_oe) begin
            inh_n++;
        end else if (ps2_clk_oe && ps2_data_oe) begin
            rts_n++;
        end else if (inh_n != 0 || rts_n != 0) begin
            check("inhibit_cycles", inh_n, INH);
            check("rts_cycles", rts_n, RTS);
            inh_n = 0;
            rts_n = 0;
        end
    end

    // Device model: waits for request-to-send, then clocks up to 11 edges.
    task automatic run_device(input int stall_after, input bit ack);
        int n;
        n = 0;
        while (!(ps2_clk_oe && ps2_data_oe) && n < INH + RTS + 100) begin
            @(negedge clock);
            n++;
        end
        check("rts_seen", int'(ps2_clk_oe && ps2_data_oe), 1);
        n = 0;
        while (ps2_clk_oe && n < RTS + 100) begin
            @(negedge clock);
            n++;
        end
        check("clk_released", int'(ps2_clk_oe), 0);
        repeat (HALF) @(negedge clock);
        for (int e = 1; e <= 11; e++) begin
            if (e == 11) begin
                if (ack) dev_data_low = 1'b1;
                repeat (4) @(negedge clock);
            end
            dev_clk_low   = 1'b1;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clock);
            if (e <= 10) dev_frame[e-1] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
            if (e == 11) dev_data_low = 1'b0;
            if (e == stall_after) break;
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!tx_ready && n < TMO * 2) begin
            @(negedge clock);
            n++;
        end
        check("ready_within_budget", int'(tx_ready), 1);
    endtask

    task automatic wait_pulse(input int p0);
        int n;
        n = 0;
        while (pulses == p0 && n < TMO + 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("pulse_within_budget", int'(pulses > p0), 1);
    endtask

    task automatic send(input logic [7:0] b, input int stall, input bit ack);
        exp_t e;
        int   p0;
        wait_ready();
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check("ready_drops", int'(tx_ready), 0);
        e.ok    = (stall == 0) && ack;
        e.frame = ref_frame(b);
        sb_q.push_back(e);
        p0 = pulses;
        run_device(stall, ack);
        wait_pulse(p0);
        if (stall != 0) check("timeout_latency", err_cyc - last_fall_cyc, TMO + SYNC_LAT);
    endtask

    initial begin
        #(90000 * 20);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   acc0;
        int   p0;

        repeat (3) @(negedge clock);
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_tx_done", int'(tx_done), 0);
        check("reset_tx_error", int'(tx_error), 0);
        check("reset_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        send(8'hED, 0, 1'b1);
        send(8'h00, 0, 1'b1);
        send(8'hFF, 0, 1'b1);
        for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 0, 1'b1);

        // Device leaves data high on edge 11.
        send(8'($urandom_range(0, 255)), 0, 1'b0);
        // Device stops clocking part way through.
        send(8'($urandom_range(0, 255)), 5, 1'b1);
        send(8'($urandom_range(0, 255)), int'($urandom_range(1, 10)), 1'b1);

        // tx_valid held with a new byte while busy.
        wait_ready();
        acc0     = n_acc;
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_data = 8'h55;
        check("hold_ready_drops", int'(tx_ready), 0);
        e.ok    = 1'b1;
        e.frame = ref_frame(8'hA3);
        sb_q.push_back(e);
        p0 = pulses;
        run_device(0, 1'b1);
        wait_pulse(p0);
        check("busy_valid_ignored", n_acc - acc0, 1);
        @(negedge clock);
        #1;
        tx_valid = 1'b0;
        check("held_byte_accepted_first_ready", n_acc - acc0, 2);
        check("held_ready_low", int'(tx_ready), 0);
        e.frame = ref_frame(8'h55);
        sb_q.push_back(e);
        p0 = pulses;
        run_device(0, 1'b1);
        wait_pulse(p0);

        // Reset during SEND.
        wait_ready();
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        run_device(3, 1'b1);
        check("send_data_oe_before_reset", int'(ps2_data_oe), 1);
        resetn = 1'b0;
        #1;
        check("async_reset_clk_oe", int'(ps2_clk_oe), 0);
        check("async_reset_data_oe", int'(ps2_data_oe), 0);
        check("async_reset_ready", int'(tx_ready), 1);
        @(negedge clock);
        resetn = 1'b1;
        p0 = pulses;
        repeat (TMO + 100) @(negedge clock);
        check("no_pulse_after_reset", pulses - p0, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
